button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of GameController. Takes the raw, asynchronous board buttons and switches (left, right, A, B, pause) and synchronises them into the CLK domain. Each channel is then debounced and given edge pulses plus a hold-to-repeat pulse. The top level feeds the clean levels and pulses to the controller in place of the raw pins.

Parameters:
NUM_INPUTS, 5, number of conditioned channels (bit order: 0 left, 1 right, 2 A, 3 B, 4 pause)
DEBOUNCE_CYCLES, 400000, cycles the synchronised input must hold a new value before it is accepted (10 ms at 40 MHz); legal range >= 1
REPEAT_DELAY, 16000000, cycles from press to first auto-repeat pulse (400 ms); 0 disables auto-repeat
REPEAT_PERIOD, 4000000, cycles between subsequent auto-repeat pulses (100 ms); legal range >= 1

Ports:
CLK  in  1  system clock, 40 MHz
RESET  in  1  synchronous, active-high reset
RAW_IN  in  NUM_INPUTS  asynchronous button/switch pins
LEVEL  out  NUM_INPUTS  debounced level per channel
PRESS  out  NUM_INPUTS  1-cycle pulse on accepted 0->1
RELEASE  out  NUM_INPUTS  1-cycle pulse on accepted 1->0
REPEAT  out  NUM_INPUTS  1-cycle pulse on press and on each auto-repeat while held

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is CLK and reset port is RESET, as elsewhere in the design.
- Reset values: sync flops 0, LEVEL 0, PRESS/RELEASE/REPEAT 0, all counters 0. While RESET is high, no pulses are produced.
- Reset mid-debounce or mid-hold discards all progress. After reset is released, a button still held must be re-debounced, and it then produces PRESS as normal.
- Synchroniser: two flops per channel (sync1 <= RAW_IN, sync2 <= sync1). Only sync2 is used downstream.
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == LEVEL: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: LEVEL <= sync2 and counter <= 0.
  - Else: counter <= counter+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never changes LEVEL. It also resets the count, so there is no accumulation across glitches.
- Latency: with RAW_IN stable at a new value from cycle 0 (first sampling edge), LEVEL changes on edge DEBOUNCE_CYCLES+1, i.e. visible in cycle DEBOUNCE_CYCLES+2.
- PRESS and RELEASE are registered. They are high for exactly the one cycle in which LEVEL first shows its new value. They never overlap on the same channel.
- Repeat state machine, per channel:
  - States: IDLE, DELAY, REPEATING.
  - IDLE -> DELAY on accepted press. REPEAT pulses in the same cycle as PRESS. Repeat counter <= 0.
  - DELAY: count up. At REPEAT_DELAY-1, pulse REPEAT, move to REPEATING, counter <= 0.
  - REPEATING: count up. At REPEAT_PERIOD-1, pulse REPEAT, counter <= 0.
  - Any state -> IDLE when LEVEL is 0, and no further REPEAT pulses occur.
  - A release in the same cycle as a repeat boundary suppresses that pulse.
  - With REPEAT_DELAY == 0, the state machine stays in IDLE and REPEAT equals PRESS.
  - Counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). No wrap is possible because the counter is cleared at terminal count.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.

Decomposition:
- Shared package game_pkg holds:
  - the button index constants (BTN_IDX_LEFT=0, RIGHT=1, A=2, B=3, PAUSE=4);
  - the default timing constants, derived from CLK_HZ=40000000 (DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_PERIOD_MS);
  - the repeat state enum.
- Natural sub-module: button_channel, containing the synchroniser, debounce and repeat logic for one bit. The top generates NUM_INPUTS instances.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.)
- Reset, RAW_IN=5'b11111 during and after -> LEVEL stays 0 through reset. LEVEL[4:0] goes 11111 exactly 6 cycles after the first post-reset edge, with PRESS=11111 and REPEAT=11111 for that single cycle.
- RAW_IN[0] 3-cycle high glitch, repeated 5 times with 1-cycle lows in between -> LEVEL[0], PRESS[0] and REPEAT[0] stay 0 throughout.
- Hold RAW_IN[2] high for 40 cycles after acceptance -> REPEAT[2] pulses at offsets 0, 10, 13, 16, ... relative to PRESS[2]. After release, RELEASE[2] pulses once 6 cycles after the falling input and REPEAT[2] goes silent.
- Press ch0 and ch1 on the same edge, release ch1 while ch0 is held -> independent pulses. ch0's repeat sequence is unaffected.
- Assert RESET while ch3 is in REPEATING -> all outputs 0 next cycle. After deassertion with the button still held, PRESS[3] reappears 6 cycles later.
- Parameter run with REPEAT_DELAY=0 -> REPEAT identical to PRESS on every channel for a 50-cycle hold.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants and types for the game input path: button indices,
// default timing derived from the 40 MHz system clock, and the repeat FSM states.
package game_pkg;

  localparam int BTN_IDX_LEFT  = 0;
  localparam int BTN_IDX_RIGHT = 1;
  localparam int BTN_IDX_A     = 2;
  localparam int BTN_IDX_B     = 3;
  localparam int BTN_IDX_PAUSE = 4;

  localparam int CLK_HZ           = 40_000_000;
  localparam int CYCLES_PER_MS    = CLK_HZ / 1000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int REPEAT_DELAY_MS  = 400;
  localparam int REPEAT_PERIOD_MS = 100;

  localparam int DEBOUNCE_CYCLES_DEF = DEBOUNCE_MS * CYCLES_PER_MS;
  localparam int REPEAT_DELAY_DEF    = REPEAT_DELAY_MS * CYCLES_PER_MS;
  localparam int REPEAT_PERIOD_DEF   = REPEAT_PERIOD_MS * CYCLES_PER_MS;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEATING
  } rpt_state_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioned button: two-flop synchroniser, debounce filter,
// registered press/release pulses and a hold-to-repeat state machine.
module button_channel
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_W = $clog2(maxInt(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam bit RPT_EN = (REPEAT_DELAY != 0);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [DB_W-1:0]  dbCnt_q, dbCnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  rpt_state_e       state_q, state_d;
  logic [RPT_W-1:0] rptCnt_q, rptCnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      dbCnt_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= RPT_IDLE;
      rptCnt_q  <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      dbCnt_q   <= dbCnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      rptCnt_q  <= rptCnt_d;
    end
  end

  always_comb begin
    sync1_d   = raw_i;
    sync2_d   = sync1_q;
    level_d   = level_q;
    dbCnt_d   = dbCnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (sync2_q == level_q) begin
      dbCnt_d = '0;
    end else if (dbCnt_q == DB_LAST) begin
      level_d   = sync2_q;
      dbCnt_d   = '0;
      press_d   = sync2_q;
      release_d = ~sync2_q;
    end else begin
      dbCnt_d = dbCnt_q + 1'b1;
    end

    // Decisions use the next level so a release landing on a boundary kills that pulse.
    state_d  = state_q;
    rptCnt_d = rptCnt_q;
    repeat_d = press_d;

    if (!level_d) begin
      state_d  = RPT_IDLE;
      rptCnt_d = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (press_d && RPT_EN) begin
            state_d  = RPT_DELAY;
            rptCnt_d = '0;
          end
        end
        RPT_DELAY: begin
          if (rptCnt_q == DELAY_LAST) begin
            repeat_d = 1'b1;
            state_d  = RPT_REPEATING;
            rptCnt_d = '0;
          end else begin
            rptCnt_d = rptCnt_q + 1'b1;
          end
        end
        RPT_REPEATING: begin
          if (rptCnt_q == PERIOD_LAST) begin
            repeat_d = 1'b1;
            rptCnt_d = '0;
          end else begin
            rptCnt_d = rptCnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = RPT_IDLE;
          rptCnt_d = '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw board buttons for GameController: one independent
// button_channel per input bit, all in the CLK domain.
module button_conditioner
  import game_pkg::*;
#(
  parameter int NUM_INPUTS      = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_INPUTS-1:0] RAW_IN,
  output logic [NUM_INPUTS-1:0] LEVEL,
  output logic [NUM_INPUTS-1:0] PRESS,
  output logic [NUM_INPUTS-1:0] RELEASE,
  output logic [NUM_INPUTS-1:0] REPEAT
);

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : gChannel
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) uChannel (
      .clk_i    (CLK),
      .reset_i  (RESET),
      .raw_i    (RAW_IN[g]),
      .level_o  (LEVEL[g]),
      .press_o  (PRESS[g]),
      .release_o(RELEASE[g]),
      .repeat_o (REPEAT[g])
    );
  end

endmodule
